// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, fetch capture, decode field split,
// stall hold, branch redirect with bubble insertion, sticky misalignment flag and stall counter.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc_plus4,
  output logic [5:0]       id_opcode,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_rd,
  output logic [5:0]       id_funct,
  output logic [15:0]      id_imm16,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [31:0]      PcStep = 32'(PC_STEP);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun, StHold: begin
        // Redirect wins over stall, even while holding.
        if (branch_taken) begin
          pc_d       = {branch_target[31:2], 2'b00};
          valid_d    = 1'b0;
          instr_d    = '0;
          pc_plus4_d = '0;
          state_d    = StRun;
          if (branch_target[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (stall) begin
          state_d = StHold;
          if (cnt_q != '1) cnt_d = cnt_q + CntOne;
        end else begin
          instr_d    = imem_rdata;
          pc_plus4_d = pc_q + PcStep;
          valid_d    = 1'b1;
          pc_d       = pc_q + PcStep;
          state_d    = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  assign imem_addr    = pc_q;
  assign id_valid     = valid_q;
  assign id_instr     = instr_q;
  assign id_pc_plus4  = pc_plus4_q;
  assign id_opcode    = instr_q[31:26];
  assign id_rs        = instr_q[25:21];
  assign id_rt        = instr_q[20:16];
  assign id_rd        = instr_q[15:11];
  assign id_funct     = instr_q[5:0];
  assign id_imm16     = instr_q[15:0];
  assign misalign_err = misalign_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: a behavioural reference model predicts each edge,
// predictions are queued when stimulus is driven and compared after the edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic        misalign_err;
  logic [15:0] stall_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic        m_boot, m_valid, m_mis;
  logic [31:0] m_instr, m_p4;
  logic [15:0] m_cnt;

  if_id_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_funct     (id_funct),
    .id_imm16     (id_imm16),
    .misalign_err (misalign_err),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2009_FFFF;
      32'h0000_0004: return 32'h8D2A_0010;
      default:       return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1'b1; m_valid = 1'b0; m_instr = '0;
    m_p4 = '0; m_mis = 1'b0; m_cnt = '0;
  endtask

  // Drive one cycle, predict, wait the edge, compare.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    stall = st; branch_taken = br; branch_target = tgt;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_instr = '0; m_p4 = '0;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end else if (st) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_instr = mem_word(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_p4    = m_pc;
    end
    e = '{addr: m_pc, valid: m_valid, instr: m_instr, p4: m_p4, mis: m_mis, cnt: m_cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("imem_addr", imem_addr, got.addr);
    check("id_valid", {31'b0, id_valid}, {31'b0, got.valid});
    check("id_instr", id_instr, got.instr);
    check("id_pc_plus4", id_pc_plus4, got.p4);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, got.mis});
    check("stall_count", {16'b0, stall_count}, {16'b0, got.cnt});
    check("fields", {id_opcode, id_rs, id_rt, id_funct, id_imm16[9:0]},
          {got.instr[31:26], got.instr[25:21], got.instr[20:16], got.instr[5:0],
           got.instr[9:0]});
    check("id_rd_imm", {11'b0, id_rd, id_imm16}, {11'b0, got.instr[15:11], got.instr[15:0]});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    model_reset();
    #2;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_p4", id_pc_plus4, 32'h0);
    check("rst_cnt", {16'b0, stall_count}, 32'h0);

    // T1: release mid-cycle; BOOT edge ignores inputs
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 32'h0000_0080);
    check("t1_boot_addr", imem_addr, 32'h0);
    // T2: sequential fetch
    step(1'b0, 1'b0, '0);
    check("t2_imm0", {16'b0, id_imm16}, 32'h0000_FFFF);
    check("t2_rt0", {27'b0, id_rt}, 32'd9);
    step(1'b0, 1'b0, '0);
    check("t2_imm1", {16'b0, id_imm16}, 32'h0000_0010);
    check("t2_rs1", {27'b0, id_rs}, 32'd9);
    check("t2_pc", imem_addr, 32'h8);
    // T3: three-cycle stall
    repeat (3) step(1'b1, 1'b0, '0);
    check("t3_cnt", {16'b0, stall_count}, 32'd3);
    check("t3_addr", imem_addr, 32'h8);
    step(1'b0, 1'b0, '0);
    check("t3_resume_p4", id_pc_plus4, 32'hC);
    // T4: branch overrides stall, from HOLD
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_0040);
    check("t4_bubble", {31'b0, id_valid}, 32'h0);
    check("t4_pc", imem_addr, 32'h40);
    step(1'b0, 1'b0, '0);
    check("t4_fetch_p4", id_pc_plus4, 32'h44);
    // T5: misaligned target and PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    check("t5_pc", imem_addr, 32'hFFFF_FFFC);
    check("t5_mis", {31'b0, misalign_err}, 32'h1);
    step(1'b0, 1'b0, '0);
    check("t5_wrap_p4", id_pc_plus4, 32'h0);
    check("t5_wrap_pc", imem_addr, 32'h0);
    repeat (3) step(1'b0, 1'b0, '0);
    check("t5_sticky", {31'b0, misalign_err}, 32'h1);
    // T6: async reset while holding
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_valid", {31'b0, id_valid}, 32'h0);
    check("t6_cnt", {16'b0, stall_count}, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_mis", {31'b0, misalign_err}, 32'h0);

    // Randomised traffic against the model
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic st, br;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      step(st, br, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
